// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response bus for the fetch stage
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch stage with IF/ID and ID/EX instruction registers
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_stage_if.master        imem,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic [31:0]          inst_d,
  output logic [31:0]          pc_d,
  output logic                 valid_d,
  output logic [31:0]          inst_e,
  output logic                 valid_e
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state, state_n;
  logic [31:0] pc_f, pc_n;
  logic [31:0] hold_buf, hold_n;
  logic [31:0] pc_inc;
  logic        req;
  logic [31:0] addr;
  logic        deliver;
  logic [31:0] dlv_inst;
  logic [31:0] dlv_pc;

  assign pc_inc = pc_f + 32'd4;

  always_comb begin
    state_n  = state;
    pc_n     = pc_f;
    hold_n   = hold_buf;
    req      = 1'b0;
    addr     = pc_f;
    deliver  = 1'b0;
    dlv_inst = hold_buf;
    dlv_pc   = pc_f;

    case (state)
      S_REQ: begin
        req = 1'b1;
        if (imem.imem_ready) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_valid) begin
          pc_n = pc_inc;
          if (!stall) begin
            // Deliver and issue the next request in the same cycle for 1 IPC.
            deliver  = 1'b1;
            dlv_inst = imem.imem_rdata;
            dlv_pc   = pc_f;
            req      = 1'b1;
            addr     = pc_inc;
            state_n  = imem.imem_ready ? S_WAIT : S_REQ;
          end else begin
            hold_n  = imem.imem_rdata;
            state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          deliver  = 1'b1;
          dlv_inst = hold_buf;
          dlv_pc   = pc_f - 32'd4;
          state_n  = S_REQ;
        end
      end
      S_DROP: begin
        if (imem.imem_valid) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase

    // A wrong-path response still in flight must be drained before refetching.
    if (redirect) begin
      pc_n    = {redirect_pc[31:2], 2'b00};
      req     = 1'b0;
      deliver = 1'b0;
      if ((state == S_WAIT || state == S_DROP) && !imem.imem_valid)
        state_n = S_DROP;
      else
        state_n = S_REQ;
    end

    if (rst) req = 1'b0;
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      pc_f     <= RESET_PC;
      hold_buf <= NOP;
      inst_d   <= NOP;
      pc_d     <= 32'h0000_0000;
      valid_d  <= 1'b0;
      inst_e   <= NOP;
      valid_e  <= 1'b0;
    end else begin
      state    <= state_n;
      pc_f     <= pc_n;
      hold_buf <= hold_n;
      if (redirect) begin
        inst_d  <= NOP;
        valid_d <= 1'b0;
        inst_e  <= NOP;
        valid_e <= 1'b0;
      end else begin
        if (stall) begin
          inst_e  <= NOP;
          valid_e <= 1'b0;
        end else begin
          inst_e  <= inst_d;
          valid_e <= valid_d;
        end
        if (deliver) begin
          inst_d  <= dlv_inst;
          pc_d    <= dlv_pc;
          valid_d <= 1'b1;
        end else if (!stall) begin
          inst_d  <= NOP;
          valid_d <= 1'b0;
        end
      end
    end
  end

endmodule
